// File: rtl/acc_pkg.sv
// Shared types for the ap_ctrl_chain initiator and the engine controller.
package acc_pkg;

   // Batch sequencer states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_e;

   // ap_ctrl_chain signal bundle as seen from the initiator
   typedef struct packed {
      logic start;
      logic ready;
      logic done;
      logic cont;
   } ap_chain_t;

   // States in which completions are still serviced
   function automatic logic is_retire_state(input state_e s);
      return (s == ISSUE) || (s == DRAIN) || (s == ERR);
   endfunction

endpackage

// File: rtl/acc_watchdog.sv
// Idle-cycle watchdog: counts while enabled and saturates at all-ones.
module acc_watchdog #(
   parameter int TMO_W = 24
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TMO_W-1:0] cnt;

   assign expired = &cnt;

   // Clear has priority; hold once expired so the flag stays up until cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (clr)              cnt <= '0;
      else if (en && !expired)   cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/acc_ap_chain_drv.sv
// ap_ctrl_chain initiator: issues N kernel starts, retires each done with a
// one-cycle ap_continue, reports progress, batch completion and timeout.
module acc_ap_chain_drv
   import acc_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int MAX_OUTST = 2,
   parameter int TMO_W     = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_num_runs,
   input  logic             err_clear,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             busy,
   output logic             batch_done,
   output logic [CNT_W-1:0] runs_issued,
   output logic [CNT_W-1:0] runs_retired,
   output logic             timeout_err
);

   localparam logic [CNT_W-1:0] MAX_O = CNT_W'(MAX_OUTST);

   state_e           state;
   logic [CNT_W-1:0] n_runs;
   logic [CNT_W-1:0] issued_nxt;
   logic [CNT_W-1:0] retired_nxt;
   logic             start_hs;
   logic             retire_hs;
   logic             ret_st;
   logic             wd_clr;
   logic             wd_en;
   logic             wd_exp;

   assign ret_st      = is_retire_state(state);
   assign start_hs    = ap_start && ap_ready;
   assign retire_hs   = ap_done && ap_continue && ret_st;
   assign issued_nxt  = runs_issued + CNT_W'(start_hs);
   assign retired_nxt = runs_retired + CNT_W'(retire_hs);

   assign wd_clr = start_hs || retire_hs || (state == IDLE) || (state == DONE);
   assign wd_en  = (state == ISSUE) || (state == DRAIN);

   acc_watchdog #(.TMO_W(TMO_W)) u_wd (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_exp)
   );

   // Batch FSM with registered handshake and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         n_runs       <= '0;
         runs_issued  <= '0;
         runs_retired <= '0;
         cmd_ready    <= 1'b0;
         ap_start     <= 1'b0;
         ap_continue  <= 1'b0;
         busy         <= 1'b0;
         batch_done   <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         batch_done   <= 1'b0;
         // One continue pulse per done; a done still high right after it is skipped once
         ap_continue  <= ret_st && ap_done && !ap_continue;
         runs_issued  <= issued_nxt;
         runs_retired <= retired_nxt;
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  n_runs       <= cmd_num_runs;
                  runs_issued  <= '0;
                  runs_retired <= '0;
                  cmd_ready    <= 1'b0;
                  if (cmd_num_runs == '0) begin
                     state <= DONE;
                  end else begin
                     state    <= ISSUE;
                     busy     <= 1'b1;
                     ap_start <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (wd_exp) begin
                  state       <= ERR;
                  ap_start    <= 1'b0;
                  timeout_err <= 1'b1;
               end else if (issued_nxt == n_runs) begin
                  state    <= DRAIN;
                  ap_start <= 1'b0;
               end else begin
                  // Registered retire count: conservative by one cycle
                  ap_start <= (issued_nxt - runs_retired) < MAX_O;
               end
            end
            DRAIN: begin
               if (wd_exp) begin
                  state       <= ERR;
                  timeout_err <= 1'b1;
               end else if (retired_nxt == n_runs) begin
                  state <= DONE;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               batch_done <= 1'b1;
               cmd_ready  <= 1'b1;
               state      <= IDLE;
            end
            ERR: begin
               ap_start <= 1'b0;
               if (err_clear) begin
                  state       <= IDLE;
                  timeout_err <= 1'b0;
                  busy        <= 1'b0;
                  cmd_ready   <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Completions can never outrun starts
   a_ret_le_iss: assert property (@(posedge clk) disable iff (!rst_n)
      runs_retired <= runs_issued);

endmodule

// File: tb/tb_acc_ap_chain_drv.sv
// Directed bench for acc_ap_chain_drv with a small ap_ctrl_chain kernel model.
module tb_acc_ap_chain_drv;

   localparam int CNT_W     = 16;
   localparam int MAX_OUTST = 2;
   localparam int TMO_W     = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_num_runs = '0;
   logic             err_clear = 1'b0;
   logic             ap_start;
   logic             ap_ready = 1'b1;
   logic             ap_done = 1'b0;
   logic             ap_continue;
   logic             busy;
   logic             batch_done;
   logic [CNT_W-1:0] runs_issued;
   logic [CNT_W-1:0] runs_retired;
   logic             timeout_err;

   int total = 0;
   int bad   = 0;
   int done_dly = 5;
   int cyc = 0;
   int q[$];
   int m_st = 0, m_co = 0, m_bd = 0, m_out = 0, m_max = 0, m_viol = 0;

   always #5 clk = ~clk;

   acc_ap_chain_drv #(.CNT_W(CNT_W), .MAX_OUTST(MAX_OUTST), .TMO_W(TMO_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_num_runs (cmd_num_runs),
      .err_clear    (err_clear),
      .ap_start     (ap_start),
      .ap_ready     (ap_ready),
      .ap_done      (ap_done),
      .ap_continue  (ap_continue),
      .busy         (busy),
      .batch_done   (batch_done),
      .runs_issued  (runs_issued),
      .runs_retired (runs_retired),
      .timeout_err  (timeout_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Kernel model: done rises done_dly edges after its start, held until continue,
   // low for at least one cycle between completions. Also tracks handshakes.
   always @(posedge clk) begin : kern
      logic st, rt, co, bd;
      st = ap_start && ap_ready;
      rt = ap_done && ap_continue;
      co = ap_continue;
      bd = batch_done;
      cyc++;
      #1;
      if (!rst_n) begin
         q.delete();
         ap_done = 1'b0;
         m_out   = 0;
      end else begin
         if (st) begin
            m_st++;
            m_out++;
            q.push_back(cyc + done_dly);
         end
         if (co) m_co++;
         if (bd) m_bd++;
         if (rt) begin
            m_out--;
            ap_done = 1'b0;
            void'(q.pop_front());
         end else if (!ap_done && q.size() > 0 && q[0] <= cyc) begin
            ap_done = 1'b1;
         end
         if (m_out > m_max) m_max = m_out;
         if (m_out >= MAX_OUTST && ap_start) m_viol++;
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic run_cmd(input logic [CNT_W-1:0] n);
      int k = 0;
      while (!cmd_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      cmd_valid    = 1'b1;
      cmd_num_runs = n;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_bd(input int lim);
      int k = 0;
      while (!batch_done && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk("bd_seen", 64'(batch_done), 64'd1);
      @(negedge clk);
      chk("bd_one_cycle", 64'(batch_done), 64'd0);
      chk("busy_after", 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int k;
      int b_st, b_co, b_bd;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_outs", 64'({ap_start, ap_continue, busy, batch_done, cmd_ready, timeout_err,
                           runs_issued, runs_retired}), 64'd0);
      rst_n = 1'b1;

      // 1: N=3, done 5 cycles after each start
      done_dly = 5;
      b_st = m_st; b_co = m_co; b_bd = m_bd;
      run_cmd(16'd3);
      chk("t1_busy", 64'(busy), 64'd1);
      wait_bd(100);
      chk("t1_starts", 64'(m_st - b_st), 64'd3);
      chk("t1_conts", 64'(m_co - b_co), 64'd3);
      chk("t1_issued", 64'(runs_issued), 64'd3);
      chk("t1_retired", 64'(runs_retired), 64'd3);
      chk("t1_bd_count", 64'(m_bd - b_bd), 64'd1);

      // 2: N=4, outstanding limit
      done_dly = 2;
      b_st = m_st;
      run_cmd(16'd4);
      wait_bd(100);
      chk("t2_starts", 64'(m_st - b_st), 64'd4);
      chk("t2_issued", 64'(runs_issued), 64'd4);
      chk("t2_retired", 64'(runs_retired), 64'd4);
      chk("t2_max_outst", 64'(m_max), 64'd2);
      chk("t2_start_at_limit", 64'(m_viol), 64'd0);

      // 3: N=0 -> batch_done two cycles after accept, no start
      b_st = m_st;
      run_cmd(16'd0);
      chk("t3_bd_c1", 64'(batch_done), 64'd0);
      chk("t3_busy", 64'(busy), 64'd0);
      chk("t3_cmd_ready_low", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("t3_bd_c2", 64'(batch_done), 64'd1);
      chk("t3_cnts", 64'({runs_issued, runs_retired}), 64'd0);
      @(negedge clk);
      chk("t3_bd_c3", 64'(batch_done), 64'd0);
      chk("t3_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("t3_no_start", 64'(m_st - b_st), 64'd0);

      // 4: ready tied low -> watchdog timeout, then err_clear
      ap_ready = 1'b0;
      run_cmd(16'd2);
      k = 0;
      while (!timeout_err && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("t4_tmo_latency", 64'(k), 64'd16);
      chk("t4_tmo", 64'(timeout_err), 64'd1);
      chk("t4_start_low", 64'(ap_start), 64'd0);
      chk("t4_busy", 64'(busy), 64'd1);
      chk("t4_cmd_held", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("t4_sticky", 64'(timeout_err), 64'd1);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("t4_clr_tmo", 64'(timeout_err), 64'd0);
      chk("t4_clr_busy", 64'(busy), 64'd0);
      chk("t4_clr_ready", 64'(cmd_ready), 64'd1);
      ap_ready = 1'b1;

      // 5: start handshake and retire on the same edge
      done_dly = 1;
      run_cmd(16'd2);
      chk("t5_start", 64'(ap_start), 64'd1);
      @(negedge clk);
      ap_ready = 1'b0;
      k = 0;
      while (!ap_continue && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("t5_cont", 64'(ap_continue), 64'd1);
      chk("t5_start_pend", 64'(ap_start), 64'd1);
      chk("t5_pre", 64'({runs_issued, runs_retired}), 64'({16'd1, 16'd0}));
      ap_ready = 1'b1;
      @(negedge clk);
      chk("t5_both", 64'({runs_issued, runs_retired}), 64'({16'd2, 16'd1}));
      wait_bd(100);
      chk("t5_final", 64'({runs_issued, runs_retired}), 64'({16'd2, 16'd2}));

      // 6: async reset mid-DRAIN with done high, then a clean N=1 batch
      done_dly = 4;
      run_cmd(16'd1);
      k = 0;
      while (!ap_done && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("t6_in_drain", 64'({busy, ap_start, runs_issued}), 64'({1'b1, 1'b0, 16'd1}));
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_rst", 64'({ap_start, ap_continue, busy, batch_done, cmd_ready, timeout_err,
                               runs_issued, runs_retired}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      b_bd = m_bd;
      run_cmd(16'd1);
      wait_bd(100);
      chk("t6_final", 64'({runs_issued, runs_retired}), 64'({16'd1, 16'd1}));
      chk("t6_bd_count", 64'(m_bd - b_bd), 64'd1);
      chk("t6_viol", 64'(m_viol), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
